regfile_mp: RTL and testbench

//  Parametrised multi-port integer register file with write-through bypass, per-register

---
 rtl/regfile_mp_pkg.sv | 13 +
 rtl/regfile_bypass.sv | 30 +++
 rtl/regfile_mp.sv | 114 +++++++++++
 tb/tb_regfile_mp.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_mp_pkg.sv
// Shared configuration for the multi-port register file: default sizes, zero word
// and the INIT/RUN state encoding.
package regfile_mp_pkg;

   localparam int unsigned XLEN_DEF = 32;
   localparam int unsigned NREG_DEF = 32;

   localparam logic [XLEN_DEF-1:0] ZERO = '0;

   localparam logic ST_INIT = 1'b0;
   localparam logic ST_RUN  = 1'b1;

endpackage

// File: rtl/regfile_bypass.sv
// Per-read-port write-through bypass: picks the highest-index write port whose
// address matches the read address.
module regfile_bypass
   import regfile_mp_pkg::*;
#(
   parameter int unsigned XLEN = XLEN_DEF,
   parameter int unsigned AW   = 5,
   parameter int unsigned NWR  = 2
) (
   input  logic [NWR-1:0]      wr_en,
   input  logic [NWR*AW-1:0]   wr_addr,
   input  logic [NWR*XLEN-1:0] wr_data,
   input  logic [AW-1:0]       rd_addr,
   output logic                hit,
   output logic [XLEN-1:0]     data
);

   // Ascending scan: a later (higher-index) match overrides an earlier one.
   always_comb begin
      hit  = 1'b0;
      data = '0;
      for (int p = 0; p < NWR; p++) begin
         if (wr_en[p] && (wr_addr[p*AW +: AW] == rd_addr)) begin
            hit  = 1'b1;
            data = wr_data[p*XLEN +: XLEN];
         end
      end
   end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with write-through bypass, per-register pending
// bits and a one-register-per-cycle zero-init walker after reset.
module regfile_mp
   import regfile_mp_pkg::*;
#(
   parameter int unsigned XLEN = XLEN_DEF,
   parameter int unsigned NREG = NREG_DEF,
   parameter int unsigned AW   = $clog2(NREG),
   parameter int unsigned NRD  = 2,
   parameter int unsigned NWR  = 2
) (
   input  logic                clk,
   input  logic                rst,
   output logic                ready,
   input  logic [NWR-1:0]      wr_en,
   input  logic [NWR*AW-1:0]   wr_addr,
   input  logic [NWR*XLEN-1:0] wr_data,
   input  logic [NRD-1:0]      rd_en,
   input  logic [NRD*AW-1:0]   rd_addr,
   output logic [NRD*XLEN-1:0] rd_data,
   output logic [NRD-1:0]      rd_busy,
   input  logic                iss_en,
   input  logic [AW-1:0]       iss_addr
);

   logic                state;
   logic [AW-1:0]       idx;
   logic [NREG-1:0]     pending;
   logic [NREG-1:0]     pending_d;
   logic [XLEN-1:0]     mem [NREG];
   logic [NRD-1:0]      byp_hit;
   logic [NRD*XLEN-1:0] byp_data;
   logic                run;

   assign run   = (state == ST_RUN);
   assign ready = run;

   // Guards against addresses beyond the last register when NREG is not a power of two.
   function automatic logic in_range(input logic [AW-1:0] a);
      return (32'(a) < NREG);
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_INIT;
         idx     <= '0;
         pending <= '0;
      end else begin
         if (!run) begin
            if (idx == AW'(NREG - 1)) state <= ST_RUN;
            idx <= idx + 1'b1;
         end
         pending <= pending_d;
      end
   end

   // Storage has no reset so it can map onto RAM; INIT walks it to zero instead.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (!run) begin
            mem[idx] <= XLEN'(ZERO);
         end else begin
            for (int p = 0; p < NWR; p++) begin
               if (wr_en[p] && (wr_addr[p*AW +: AW] != '0) && in_range(wr_addr[p*AW +: AW])) begin
                  mem[wr_addr[p*AW +: AW]] <= wr_data[p*XLEN +: XLEN];
               end
            end
         end
      end
   end

   // Set after clear: an issue to the register being written keeps it pending.
   always_comb begin
      pending_d = pending;
      if (run) begin
         for (int p = 0; p < NWR; p++) begin
            if (wr_en[p] && (wr_addr[p*AW +: AW] != '0) && in_range(wr_addr[p*AW +: AW])) begin
               pending_d[wr_addr[p*AW +: AW]] = 1'b0;
            end
         end
         if (iss_en && (iss_addr != '0) && in_range(iss_addr)) begin
            pending_d[iss_addr] = 1'b1;
         end
      end
   end

   for (genvar r = 0; r < NRD; r++) begin : g_byp
      regfile_bypass #(
         .XLEN (XLEN),
         .AW   (AW),
         .NWR  (NWR)
      ) u_byp (
         .wr_en   (wr_en),
         .wr_addr (wr_addr),
         .wr_data (wr_data),
         .rd_addr (rd_addr[r*AW +: AW]),
         .hit     (byp_hit[r]),
         .data    (byp_data[r*XLEN +: XLEN])
      );
   end

   always_comb begin
      rd_data = '0;
      rd_busy = '0;
      for (int r = 0; r < NRD; r++) begin
         if (run && rd_en[r] && (rd_addr[r*AW +: AW] != '0) && in_range(rd_addr[r*AW +: AW])) begin
            rd_data[r*XLEN +: XLEN] = byp_hit[r] ? byp_data[r*XLEN +: XLEN]
                                                 : mem[rd_addr[r*AW +: AW]];
            rd_busy[r] = pending[rd_addr[r*AW +: AW]] & ~byp_hit[r];
         end
      end
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scenarios plus random traffic checked
// against a behavioural array/scoreboard model.
module tb_regfile_mp;

   localparam int XLEN = 32;
   localparam int NREG = 32;
   localparam int AW   = 5;
   localparam int NRD  = 2;
   localparam int NWR  = 2;

   logic                clk = 1'b0;
   logic                rst;
   logic                ready;
   logic [NWR-1:0]      wr_en;
   logic [NWR*AW-1:0]   wr_addr;
   logic [NWR*XLEN-1:0] wr_data;
   logic [NRD-1:0]      rd_en;
   logic [NRD*AW-1:0]   rd_addr;
   logic [NRD*XLEN-1:0] rd_data;
   logic [NRD-1:0]      rd_busy;
   logic                iss_en;
   logic [AW-1:0]       iss_addr;

   always #5 clk = ~clk;

   regfile_mp #(
      .XLEN (XLEN),
      .NREG (NREG),
      .NRD  (NRD),
      .NWR  (NWR)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .ready    (ready),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .rd_en    (rd_en),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data),
      .rd_busy  (rd_busy),
      .iss_en   (iss_en),
      .iss_addr (iss_addr)
   );

   int errors = 0;
   int checks = 0;

   // Reference: register values, pending flags, cycles spent initialising since reset.
   logic [XLEN-1:0] ref_mem  [NREG];
   bit              ref_pend [NREG];
   int              ref_cnt   = 0;
   bit              ref_valid = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic model_check();
      logic [XLEN-1:0] d;
      logic [AW-1:0]   a;
      bit              b;
      bit              hit;
      if (!ref_valid) return;
      check("ready", 32'(ready), 32'(ref_cnt >= NREG));
      for (int r = 0; r < NRD; r++) begin
         a = rd_addr[r*AW +: AW];
         d = '0;
         b = 1'b0;
         if (ref_cnt >= NREG && rd_en[r] && a != 0) begin
            hit = 1'b0;
            for (int p = NWR - 1; p >= 0; p--) begin
               if (!hit && wr_en[p] && wr_addr[p*AW +: AW] == a) begin
                  hit = 1'b1;
                  d   = wr_data[p*XLEN +: XLEN];
               end
            end
            if (!hit) d = ref_mem[a];
            b = ref_pend[a] && !hit;
         end
         check($sformatf("rd_data%0d x%0d", r, a), rd_data[r*XLEN +: XLEN], d);
         check($sformatf("rd_busy%0d x%0d", r, a), 32'(rd_busy[r]), 32'(b));
      end
   endtask

   task automatic model_update();
      bit written [NREG];
      if (rst) begin
         ref_valid = 1'b1;
         ref_cnt   = 0;
         for (int i = 0; i < NREG; i++) begin
            ref_mem[i]  = '0;
            ref_pend[i] = 1'b0;
         end
      end else if (ref_valid && ref_cnt < NREG) begin
         ref_cnt++;
      end else if (ref_valid) begin
         for (int i = 0; i < NREG; i++) written[i] = 1'b0;
         for (int p = 0; p < NWR; p++) begin
            if (wr_en[p] && wr_addr[p*AW +: AW] != 0) begin
               ref_mem[wr_addr[p*AW +: AW]] = wr_data[p*XLEN +: XLEN];
               written[wr_addr[p*AW +: AW]] = 1'b1;
            end
         end
         for (int i = 1; i < NREG; i++) begin
            if (iss_en && iss_addr == AW'(i)) ref_pend[i] = 1'b1;
            else if (written[i])              ref_pend[i] = 1'b0;
         end
      end
   endtask

   task automatic cycle();
      @(negedge clk);
      model_check();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic idle();
      rst      = 1'b0;
      wr_en    = '0;
      wr_addr  = '0;
      wr_data  = '0;
      rd_en    = '0;
      rd_addr  = '0;
      iss_en   = 1'b0;
      iss_addr = '0;
   endtask

   // Small address range most of the time so ports collide often.
   function automatic logic [AW-1:0] rand_addr();
      return ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, NREG - 1))
                                         : AW'($urandom_range(0, 7));
   endfunction

   task automatic rand_inputs(input bit allow_rst);
      rst = allow_rst && ($urandom_range(0, 149) == 0);
      for (int p = 0; p < NWR; p++) begin
         wr_en[p]              = 1'($urandom_range(0, 1));
         wr_addr[p*AW +: AW]   = rand_addr();
         wr_data[p*XLEN +: XLEN] = $urandom;
      end
      for (int r = 0; r < NRD; r++) begin
         rd_en[r]            = ($urandom_range(0, 3) != 0);
         rd_addr[r*AW +: AW] = rand_addr();
      end
      iss_en   = 1'($urandom_range(0, 1));
      iss_addr = rand_addr();
   endtask

   task automatic count_init(input string tag);
      int n = 0;
      while (!ready && n < 100) begin
         rand_inputs(1'b0);
         cycle();
         n++;
      end
      check(tag, n, 32);
   endtask

   initial begin
      idle();
      rst = 1'b1;
      cycle();
      cycle();

      // Init walk: ready low exactly 32 cycles, reads zero, writes/issues ignored.
      count_init("init_len");

      // Write-through bypass, then array read.
      idle();
      wr_en = 2'b01; wr_addr[0 +: AW] = 5'd5; wr_data[0 +: XLEN] = 32'hDEADBEEF;
      rd_en = 2'b01; rd_addr[0 +: AW] = 5'd5;
      #1 check("x5_bypass", rd_data[0 +: XLEN], 32'hDEADBEEF);
      cycle();
      idle();
      rd_en = 2'b10; rd_addr[AW +: AW] = 5'd5;
      #1 check("x5_array", rd_data[XLEN +: XLEN], 32'hDEADBEEF);
      cycle();

      // Two ports to the same register: port 1 wins.
      idle();
      wr_en = 2'b11;
      wr_addr[0 +: AW] = 5'd7; wr_data[0 +: XLEN]    = 32'h1;
      wr_addr[AW +: AW] = 5'd7; wr_data[XLEN +: XLEN] = 32'h2;
      rd_en = 2'b01; rd_addr[0 +: AW] = 5'd7;
      #1 check("x7_bypass_prio", rd_data[0 +: XLEN], 32'h2);
      cycle();
      idle();
      rd_en = 2'b01; rd_addr[0 +: AW] = 5'd7;
      #1 check("x7_array_prio", rd_data[0 +: XLEN], 32'h2);
      cycle();

      // x0 is immune to writes and issues.
      idle();
      wr_en = 2'b11; wr_data = '1;
      iss_en = 1'b1; iss_addr = 5'd0;
      rd_en = 2'b10;
      #1 check("x0_data_wr", rd_data[XLEN +: XLEN], 32'h0);
      cycle();
      idle();
      rd_en = 2'b01;
      #1 check("x0_data", rd_data[0 +: XLEN], 32'h0);
      check("x0_busy", 32'(rd_busy[0]), 32'h0);
      cycle();

      // Scoreboard: issue sets pending, write clears, write+issue keeps it set.
      idle();
      iss_en = 1'b1; iss_addr = 5'd3;
      cycle();
      idle();
      rd_en = 2'b01; rd_addr[0 +: AW] = 5'd3;
      #1 check("x3_busy_issued", 32'(rd_busy[0]), 32'h1);
      cycle();
      idle();
      wr_en = 2'b01; wr_addr[0 +: AW] = 5'd3; wr_data[0 +: XLEN] = 32'h55;
      rd_en = 2'b01; rd_addr[0 +: AW] = 5'd3;
      #1 check("x3_busy_bypass", 32'(rd_busy[0]), 32'h0);
      check("x3_data_bypass", rd_data[0 +: XLEN], 32'h55);
      cycle();
      idle();
      wr_en = 2'b10; wr_addr[AW +: AW] = 5'd3; wr_data[XLEN +: XLEN] = 32'h66;
      iss_en = 1'b1; iss_addr = 5'd3;
      cycle();
      idle();
      rd_en = 2'b01; rd_addr[0 +: AW] = 5'd3;
      #1 check("x3_busy_reissued", 32'(rd_busy[0]), 32'h1);
      check("x3_data_reissued", rd_data[0 +: XLEN], 32'h66);
      cycle();

      // Reset mid-init at idx 10.
      idle();
      rst = 1'b1;
      cycle();
      idle();
      for (int i = 0; i < 10; i++) cycle();
      rst = 1'b1;
      cycle();
      idle();
      count_init("init_len_midinit");

      // Reset in RUN with x9 written and pending.
      idle();
      wr_en = 2'b01; wr_addr[0 +: AW] = 5'd9; wr_data[0 +: XLEN] = 32'hCAFE0009;
      cycle();
      idle();
      iss_en = 1'b1; iss_addr = 5'd9;
      cycle();
      idle();
      rd_en = 2'b01; rd_addr[0 +: AW] = 5'd9;
      #1 check("x9_busy_before_rst", 32'(rd_busy[0]), 32'h1);
      cycle();
      idle();
      rst = 1'b1;
      cycle();
      idle();
      count_init("init_len_run_rst");
      idle();
      rd_en = 2'b01; rd_addr[0 +: AW] = 5'd9;
      #1 check("x9_data_after_rst", rd_data[0 +: XLEN], 32'h0);
      check("x9_busy_after_rst", 32'(rd_busy[0]), 32'h0);
      cycle();

      // Random traffic against the model, with occasional resets.
      for (int i = 0; i < 600; i++) begin
         rand_inputs(1'b1);
         cycle();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
